// File: rtl/sram_stream_loader.sv
// rtl/sram_stream_loader.sv - streams int8 beats into one of NUM_SRAMS banks at consecutive addresses
module sram_stream_loader #(
    parameter int NUM_SRAMS      = 8,
    parameter int MAX_ADDR_WIDTH = 13,
    parameter int MAX_DATA_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [2:0]                           cmd_bank,
    input  logic [MAX_ADDR_WIDTH-1:0]            cmd_base,
    input  logic [MAX_ADDR_WIDTH:0]              cmd_len,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [7:0]                           s_data,
    input  logic                                 s_last,
    output logic [NUM_SRAMS-1:0]                 sram_en,
    output logic [NUM_SRAMS-1:0]                 sram_we,
    output logic [NUM_SRAMS*MAX_ADDR_WIDTH-1:0]  sram_addr,
    output logic [NUM_SRAMS*MAX_DATA_WIDTH-1:0]  sram_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int AW = MAX_ADDR_WIDTH;
    localparam int DW = MAX_DATA_WIDTH;
    localparam int LW = MAX_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             bank_q, bank_d;
    logic [AW-1:0]          base_q, base_d;
    logic [LW-1:0]          len_q, len_d;
    logic [LW-1:0]          count_q, count_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   s_ready_q, s_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [NUM_SRAMS-1:0]   en_q, en_d;
    logic [NUM_SRAMS-1:0]   we_q, we_d;
    logic [NUM_SRAMS*AW-1:0] addr_q, addr_d;
    logic [NUM_SRAMS*DW-1:0] data_q, data_d;

    logic          cmd_fire;
    logic          beat_fire;
    logic          bad_cmd;
    logic [LW-1:0] count_next;
    logic [AW-1:0] wr_addr;
    logic          len_reached;

    assign cmd_fire    = cmd_valid & cmd_ready_q;
    assign beat_fire   = s_valid & s_ready_q;
    assign bad_cmd     = (cmd_len == '0) || (int'(cmd_bank) >= NUM_SRAMS);
    assign count_next  = count_q + 1'b1;
    // Address arithmetic is modulo the bank depth; wrap is legal, not an error.
    assign wr_addr     = base_q + count_q[AW-1:0];
    assign len_reached = (count_next == len_q);

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        base_d      = base_q;
        len_d       = len_q;
        count_d     = count_q;
        cmd_ready_d = cmd_ready_q;
        s_ready_d   = s_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        en_d        = '0;
        we_d        = '0;
        addr_d      = addr_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                s_ready_d   = 1'b0;
                busy_d      = 1'b0;
                if (cmd_fire) begin
                    bank_d      = cmd_bank;
                    base_d      = cmd_base;
                    len_d       = cmd_len;
                    count_d     = '0;
                    addr_d      = '0;
                    data_d      = '0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (bad_cmd) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        s_ready_d = 1'b0;
                    end else begin
                        state_d   = ST_LOAD;
                        err_d     = 1'b0;
                        s_ready_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (beat_fire) begin
                    count_d = count_next;
                    // Only the target bank carries address/data; all others are zeroed.
                    for (int i = 0; i < NUM_SRAMS; i++) begin
                        if (int'(bank_q) == i) begin
                            en_d[i]             = 1'b1;
                            we_d[i]             = 1'b1;
                            addr_d[i*AW +: AW]  = wr_addr;
                            data_d[i*DW +: DW]  = DW'(s_data);
                        end else begin
                            addr_d[i*AW +: AW]  = '0;
                            data_d[i*DW +: DW]  = '0;
                        end
                    end
                    if (len_reached || s_last) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        s_ready_d = 1'b0;
                        err_d     = ~(len_reached & s_last);
                    end
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                s_ready_d   = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                s_ready_d   = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bank_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            en_q        <= '0;
            we_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            base_q      <= base_d;
            len_q       <= len_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign s_ready   = s_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign sram_en   = en_q;
    assign sram_we   = we_q;
    assign sram_addr = addr_q;
    assign sram_data = data_q;

endmodule

// File: tb/tb_sram_stream_loader.sv
// tb/tb_sram_stream_loader.sv - directed self-checking bench for sram_stream_loader
module tb_sram_stream_loader;

    localparam int N  = 8;
    localparam int AW = 13;
    localparam int DW = 8;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_bank;
    logic [AW-1:0]     cmd_base;
    logic [AW:0]       cmd_len;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic [N-1:0]      sram_en;
    logic [N-1:0]      sram_we;
    logic [N*AW-1:0]   sram_addr;
    logic [N*DW-1:0]   sram_data;
    logic              busy;
    logic              done;
    logic              err;

    sram_stream_loader #(
        .NUM_SRAMS      (N),
        .MAX_ADDR_WIDTH (AW),
        .MAX_DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_bank  (cmd_bank),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_chk;
    int            n_bad;
    int            exp_bank;
    logic [AW-1:0] exp_addr;
    int            nbeats;
    logic          en_acc;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        en_acc = en_acc | (|sram_en);
    endtask

    task automatic do_cmd(input int b, input logic [AW-1:0] base, input logic [AW:0] len);
        chk_eq("cmd_ready_pre", 128'(cmd_ready), 128'd1);
        cmd_valid = 1'b1;
        cmd_bank  = 3'(b);
        cmd_base  = base;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        chk_eq("busy_after_cmd", 128'(busy), 128'd1);
        chk_eq("cmd_ready_after_cmd", 128'(cmd_ready), 128'd0);
        exp_bank = b;
        exp_addr = base;
        nbeats   = 0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic vld);
        logic          hs;
        logic [N*AW-1:0] ea;
        logic [N*DW-1:0] ed;
        s_valid = vld;
        s_data  = d;
        s_last  = last;
        hs      = vld & s_ready;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (hs) begin
            ea = '0;
            ed = '0;
            ea[exp_bank*AW +: AW] = exp_addr;
            ed[exp_bank*DW +: DW] = d;
            chk_eq("wr_en",   128'(sram_en),   128'(8'd1 << exp_bank));
            chk_eq("wr_we",   128'(sram_we),   128'(8'd1 << exp_bank));
            chk_eq("wr_addr", 128'(sram_addr), 128'(ea));
            chk_eq("wr_data", 128'(sram_data), 128'(ed));
            exp_addr = exp_addr + 1'b1;
            nbeats++;
        end else begin
            chk_eq("no_wr_en", 128'(sram_en), 128'd0);
        end
    endtask

    task automatic after_done();
        tick();
        chk_eq("done_clear",  128'(done),      128'd0);
        chk_eq("idle_ready",  128'(cmd_ready), 128'd1);
        chk_eq("idle_busy",   128'(busy),      128'd0);
        chk_eq("idle_en",     128'(sram_en),   128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] vec[4];
        n_chk = 0; n_bad = 0; en_acc = 1'b0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_bank = '0; cmd_base = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        exp_bank = 0; exp_addr = '0; nbeats = 0;

        // Reset state
        tick();
        tick();
        chk_eq("rst_cmd_ready", 128'(cmd_ready), 128'd1);
        chk_eq("rst_s_ready",   128'(s_ready),   128'd0);
        chk_eq("rst_busy",      128'(busy),      128'd0);
        chk_eq("rst_done",      128'(done),      128'd0);
        chk_eq("rst_err",       128'(err),       128'd0);
        chk_eq("rst_en",        128'(sram_en),   128'd0);
        chk_eq("rst_we",        128'(sram_we),   128'd0);
        chk_eq("rst_addr",      128'(sram_addr), 128'd0);
        chk_eq("rst_data",      128'(sram_data), 128'd0);
        rst = 1'b0;
        tick();

        // Bank 2, four contiguous beats, clean end
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
        do_cmd(2, 13'h010, 14'd4);
        chk_eq("load_s_ready", 128'(s_ready), 128'd1);
        for (int i = 0; i < 4; i++) beat(vec[i], i == 3, 1'b1);
        chk_eq("b2_last_addr", 128'(sram_addr[2*AW +: AW]), 128'h013);
        chk_eq("b2_done", 128'(done), 128'd1);
        chk_eq("b2_err",  128'(err),  128'd0);
        chk_eq("b2_busy", 128'(busy), 128'd1);
        chk_eq("b2_s_ready_off", 128'(s_ready), 128'd0);
        after_done();

        // Bank 7, address wrap, started back-to-back
        do_cmd(7, 13'h1FFE, 14'd4);
        for (int i = 0; i < 4; i++) beat(8'(8'hA0 + i), i == 3, 1'b1);
        chk_eq("wrap_last_addr", 128'(sram_addr[7*AW +: AW]), 128'h0001);
        chk_eq("wrap_done", 128'(done), 128'd1);
        chk_eq("wrap_err",  128'(err),  128'd0);
        after_done();

        // Early s_last: len 3, last on beat 2
        do_cmd(0, 13'h100, 14'd3);
        beat(8'h01, 1'b0, 1'b1);
        beat(8'h02, 1'b1, 1'b1);
        chk_eq("early_writes", 128'(nbeats), 128'd2);
        chk_eq("early_done", 128'(done), 128'd1);
        chk_eq("early_err",  128'(err),  128'd1);
        beat(8'hEE, 1'b0, 1'b1);
        chk_eq("early_no_extra", 128'(nbeats), 128'd2);
        chk_eq("err_sticky", 128'(err), 128'd1);
        chk_eq("early_idle", 128'(cmd_ready), 128'd1);

        // Missing s_last: len 2
        do_cmd(5, 13'h0AA, 14'd2);
        chk_eq("err_cleared", 128'(err), 128'd0);
        beat(8'h5A, 1'b0, 1'b1);
        beat(8'h5B, 1'b0, 1'b1);
        chk_eq("nolast_done", 128'(done), 128'd1);
        chk_eq("nolast_err",  128'(err),  128'd1);
        after_done();

        // Zero-length command
        en_acc = 1'b0;
        do_cmd(1, 13'h020, 14'd0);
        for (int k = 0; k < 2 && !done; k++) tick();
        chk_eq("len0_done", 128'(done), 128'd1);
        chk_eq("len0_err",  128'(err),  128'd1);
        after_done();
        chk_eq("len0_no_wr", 128'(en_acc), 128'd0);

        // Random s_valid gaps over 16 beats; a competing command is held meanwhile
        do_cmd(3, 13'h100, 14'd16);
        cmd_valid = 1'b1; cmd_bank = 3'd6; cmd_base = 13'h555; cmd_len = 14'd1;
        for (int cyc = 0; cyc < 300 && nbeats < 16; cyc++) begin
            if (cyc == 6) cmd_valid = 1'b0;
            if (cmd_valid) chk_eq("load_cmd_ready", 128'(cmd_ready), 128'd0);
            beat(8'(nbeats * 5 + 1), nbeats == 15, 1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
        chk_eq("rand_beats", 128'(nbeats), 128'd16);
        chk_eq("rand_end_addr", 128'(exp_addr), 128'h110);
        chk_eq("rand_done", 128'(done), 128'd1);
        chk_eq("rand_err",  128'(err),  128'd0);
        after_done();

        // Reset mid-transfer
        do_cmd(4, 13'h000, 14'd8);
        for (int i = 0; i < 3; i++) beat(8'(8'h70 + i), 1'b0, 1'b1);
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h99;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        chk_eq("mrst_en",        128'(sram_en),   128'd0);
        chk_eq("mrst_we",        128'(sram_we),   128'd0);
        chk_eq("mrst_addr",      128'(sram_addr), 128'd0);
        chk_eq("mrst_data",      128'(sram_data), 128'd0);
        chk_eq("mrst_cmd_ready", 128'(cmd_ready), 128'd1);
        chk_eq("mrst_s_ready",   128'(s_ready),   128'd0);
        chk_eq("mrst_busy",      128'(busy),      128'd0);
        chk_eq("mrst_done",      128'(done),      128'd0);
        tick();
        chk_eq("mrst_no_pulse", 128'(sram_en), 128'd0);

        // Single-beat transfer after reset
        do_cmd(0, 13'h005, 14'd1);
        beat(8'hA5, 1'b1, 1'b1);
        chk_eq("one_done", 128'(done), 128'd1);
        chk_eq("one_err",  128'(err),  128'd0);
        after_done();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
